// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_pkg
// Purpose  : Shared definitions for the seq_mul sequential multiplier:
//            control FSM state encoding and default operand width.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mul_pkg;

    // Default operand width used when a block is instantiated without override.
    localparam int unsigned c_default_width = 8;

    // Control FSM encoding; values are fixed so that state can be observed
    // consistently in waveforms and by other blocks in the design.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Iteration counter width: must be able to represent WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_addsel.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_addsel
// Purpose  : Combinational select-and-add step of the shift-and-add
//            multiplier. addend = sel ? a : 0, then {cout,sum} = p + addend + cin.
// Ports    : sel  - multiplier LSB, chooses multiplicand or zero
//            a    - multiplicand
//            p    - accumulator (product high half)
//            cin  - carry register, folded into the sum
//            sum  - WIDTH-bit sum
//            cout - carry out of the top sum bit
// Revision : 1.0 - initial release
// ============================================================================
module seq_mul_addsel
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_addend;

    assign w_addend    = sel ? a : '0;
    assign {cout, sum} = {1'b0, p} + {1'b0, w_addend} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_add_mul
// Purpose  : Unsigned sequential shift-and-add multiplier core. One add/shift
//            iteration per clock; full 2*WIDTH-bit product after WIDTH
//            iterations, with a start/busy/done handshake.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            start        - request, sampled only while idle
//            multiplicand - operand A, captured on accepted start
//            multiplier   - operand B, captured on accepted start
//            busy         - high while running and in the done cycle
//            done         - one-cycle pulse, product valid
//            product      - {P,Q}; holds until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_add_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned      c_cnt_w     = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("seq_shift_add_mul: WIDTH must be at least 2");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_p;
    logic                 r_c;
    logic [c_cnt_w-1:0]   r_cnt;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;

    // ------------------------------------------------------------------------
    // Select-and-add: P + (Q[0] ? A : 0). The carry register is cleared on
    // every iteration, so its contribution as carry-in is always zero; it is
    // wired in to keep the {C,P} accumulator a single arithmetic quantity.
    // ------------------------------------------------------------------------
    seq_mul_addsel #(
        .WIDTH (WIDTH)
    ) u_addsel (
        .sel  (r_q[0]),
        .a    (r_a),
        .p    (r_p),
        .cin  (r_c),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_last_iter) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath. In RUN the add and the one-bit right shift of {C,P,Q} happen
    // in the same registered update: the new P takes the carry-out at its
    // MSB, and the sum LSB drops into the top of Q as Q retires its LSB.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_p   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= multiplicand;
                        r_q   <= multiplier;
                        r_p   <= '0;
                        r_c   <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_c   <= 1'b0;
                    r_p   <= {w_cout, w_sum[WIDTH-1:1]};
                    r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                default: begin
                    // DONE: all registers hold so the product stays stable.
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign product = {r_p, r_q};

endmodule
`default_nettype wire
